// File: rtl/sliding_window_3x3_if.sv
// Pixel-stream in, 3x3 window out. The master is the pixel source and window consumer.
// The slave is the window generator.
interface sliding_window_3x3_if;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       sof;
    logic       win_valid;
    logic [7:0] sw_pixels1;
    logic [7:0] sw_pixels2;
    logic [7:0] sw_pixels3;
    logic [7:0] sw_pixels4;
    logic [7:0] sw_pixels5;
    logic [7:0] sw_pixels6;
    logic [7:0] sw_pixels7;
    logic [7:0] sw_pixels8;
    logic [7:0] sw_pixels9;
    logic       frame_done;

    modport master (
        output pix_valid, pix_in, sof,
        input  win_valid, frame_done,
        input  sw_pixels1, sw_pixels2, sw_pixels3,
        input  sw_pixels4, sw_pixels5, sw_pixels6,
        input  sw_pixels7, sw_pixels8, sw_pixels9
    );

    modport slave (
        input  pix_valid, pix_in, sof,
        output win_valid, frame_done,
        output sw_pixels1, sw_pixels2, sw_pixels3,
        output sw_pixels4, sw_pixels5, sw_pixels6,
        output sw_pixels7, sw_pixels8, sw_pixels9
    );
endinterface

// File: rtl/sliding_window_3x3.sv
// Raster pixel stream to 3x3 neighbourhood, using two line buffers and a register window.
// Only windows that lie fully inside the frame are flagged valid. The window is updated one clock after its newest pixel.
module sliding_window_3x3 #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sliding_window_3x3_if.slave  win_if
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic {WAIT_SOF, ACTIVE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          accept, col_last, row_last;
    logic [7:0]    lb_a_rd, lb_b_rd;

    logic [7:0] win_q [9];
    logic [7:0] lb_a_q [IMG_WIDTH];
    logic [7:0] lb_b_q [IMG_WIDTH];

    // A sof pixel is always pixel (0,0), even when it arrives in the middle of a frame.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        accept       = win_if.pix_valid && (win_if.sof || state_q == ACTIVE);
        cur_col      = win_if.sof ? '0 : col_q;
        cur_row      = win_if.sof ? '0 : row_q;
        col_last     = (cur_col == COL_LAST);
        row_last     = (cur_row == ROW_LAST);
        lb_a_rd      = lb_a_q[cur_col];
        lb_b_rd      = lb_b_q[cur_col];
        win_valid_d  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        frame_done_d = accept && col_last && row_last;

        if (accept) begin
            state_d = ACTIVE;
            if (!col_last) begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end else begin
                col_d = '0;
                if (row_last) begin
                    row_d   = '0;
                    state_d = WAIT_SOF;
                end else begin
                    row_d = cur_row + RW'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_SOF;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            if (accept) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb_b_rd;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb_a_rd;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= win_if.pix_in;
            end
        end
    end

    // NOTE: the line buffers have no reset. Stale contents never reach a window that is flagged valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_b_q[cur_col] <= lb_a_rd;
            lb_a_q[cur_col] <= win_if.pix_in;
        end
    end

    assign win_if.win_valid  = win_valid_q;
    assign win_if.frame_done = frame_done_q;
    assign win_if.sw_pixels1 = win_q[0];
    assign win_if.sw_pixels2 = win_q[1];
    assign win_if.sw_pixels3 = win_q[2];
    assign win_if.sw_pixels4 = win_q[3];
    assign win_if.sw_pixels5 = win_q[4];
    assign win_if.sw_pixels6 = win_q[5];
    assign win_if.sw_pixels7 = win_q[6];
    assign win_if.sw_pixels8 = win_q[7];
    assign win_if.sw_pixels9 = win_q[8];
endmodule

// File: tb/tb_sliding_window_3x3.sv
// Bench for sliding_window_3x3 on a 4x4 image. It uses a constant table for the basic frame
// and a frame-buffer reference model for the corner cases and random traffic.
module tb_sliding_window_3x3;
    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sliding_window_3x3_if bus ();

    sliding_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk    (clk),
        .rst    (rst),
        .win_if (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int win_cnt;
    int done_cnt;

    // Reference model: pixels of the current frame by (row, col), plus the linear raster index of the next pixel.
    bit          m_active;
    int          m_idx;
    logic [7:0]  m_img [H][W];
    logic [71:0] m_win;
    bit          m_win_known;
    logic        exp_v, exp_d;

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  pix;
        logic        ev;
        logic        ed;
        logic [71:0] ew;
    } vec_t;
    vec_t vec [W*H];

    function automatic logic [71:0] dut_win();
        return {bus.sw_pixels1, bus.sw_pixels2, bus.sw_pixels3,
                bus.sw_pixels4, bus.sw_pixels5, bus.sw_pixels6,
                bus.sw_pixels7, bus.sw_pixels8, bus.sw_pixels9};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] p);
        int r, c;
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        @(posedge clk);
        exp_v = 1'b0;
        exp_d = 1'b0;
        if (v && (m_active || s)) begin
            if (s) m_idx = 0;
            r = m_idx / W;
            c = m_idx % W;
            m_img[r][c] = p;
            if (r >= 2 && c >= 2) begin
                exp_v = 1'b1;
                for (int k = 0; k < 9; k++)
                    m_win[71 - 8*k -: 8] = m_img[r - 2 + k/3][c - 2 + k%3];
                m_win_known = 1'b1;
            end else begin
                m_win_known = 1'b0;
            end
            exp_d    = (m_idx == W*H - 1);
            m_idx    = m_idx + 1;
            m_active = 1'b1;
            if (m_idx == W*H) begin
                m_idx    = 0;
                m_active = 1'b0;
            end
        end
        #1;
        check("win_valid", 72'(bus.win_valid), 72'(exp_v));
        check("frame_done", 72'(bus.frame_done), 72'(exp_d));
        if (m_win_known) check("window", dut_win(), m_win);
        if (bus.win_valid === 1'b1) win_cnt++;
        if (bus.frame_done === 1'b1) done_cnt++;
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        bus.pix_valid = 1'b1;
        bus.sof       = 1'b1;
        bus.pix_in    = 8'hA5;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        m_active    = 1'b0;
        m_idx       = 0;
        m_win       = '0;
        m_win_known = 1'b1;
        check("reset_win_valid", 72'(bus.win_valid), 72'(0));
        check("reset_frame_done", 72'(bus.frame_done), 72'(0));
        check("reset_window", dut_win(), '0);
    endtask

    task automatic run_frame(input int offset, input bit gaps);
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, i == 0, 8'(offset + i + 1));
            if (gaps) step(1'b0, 1'b0, 8'($urandom));
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
        bus.pix_in = '0;
        for (int i = 0; i < W*H; i++) begin
            vec[i].v   = 1'b1;
            vec[i].s   = (i == 0);
            vec[i].pix = 8'(i + 1);
            vec[i].ev  = 1'b0;
            vec[i].ed  = 1'b0;
            vec[i].ew  = '0;
        end
        vec[10].ev = 1'b1;
        vec[10].ew = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
        vec[11].ev = 1'b1;
        vec[11].ew = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};
        vec[14].ev = 1'b1;
        vec[14].ew = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
        vec[15].ev = 1'b1;
        vec[15].ed = 1'b1;
        vec[15].ew = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};

        // Test 1: a continuous frame, checked against the constant table.
        reset_dut();
        win_cnt = 0; done_cnt = 0;
        for (int i = 0; i < W*H; i++) begin
            step(vec[i].v, vec[i].s, vec[i].pix);
            check($sformatf("t1_valid[%0d]", i), 72'(bus.win_valid), 72'(vec[i].ev));
            check($sformatf("t1_done[%0d]", i), 72'(bus.frame_done), 72'(vec[i].ed));
            if (vec[i].ev) check($sformatf("t1_win[%0d]", i), dut_win(), vec[i].ew);
        end
        check("t1_windows", 72'(win_cnt), 72'(4));
        step(1'b0, 1'b0, 8'h00);

        // Test 2: the same frame with idle cycles interleaved.
        win_cnt = 0; done_cnt = 0;
        run_frame(0, 1'b1);
        check("t2_windows", 72'(win_cnt), 72'(4));
        check("t2_done", 72'(done_cnt), 72'(1));

        // Test 3: after reset, pixels without sof are ignored.
        reset_dut();
        win_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom));
        check("t3_no_sof_windows", 72'(win_cnt), 72'(0));
        run_frame(0, 1'b0);
        check("t3_windows", 72'(win_cnt), 72'(4));
        check("t3_done", 72'(done_cnt), 72'(1));

        // Test 4: reset after pixel 12, then a new frame with different pixel values.
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 8'(i + 1));
        reset_dut();
        win_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(200 + i));
        check("t4_dropped", 72'(win_cnt), 72'(0));
        run_frame(100, 1'b0);
        check("t4_windows", 72'(win_cnt), 72'(4));
        check("t4_done", 72'(done_cnt), 72'(1));

        // Test 5: sof again at pixel 7. The aborted frame must not report frame_done.
        win_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, 8'(i + 1));
        run_frame(0, 1'b0);
        check("t5_windows", 72'(win_cnt), 72'(4));
        check("t5_done", 72'(done_cnt), 72'(1));

        // Test 6: two frames back to back with no gap.
        win_cnt = 0; done_cnt = 0;
        run_frame(0, 1'b0);
        run_frame(50, 1'b0);
        check("t6_windows", 72'(win_cnt), 72'(8));
        check("t6_done", 72'(done_cnt), 72'(2));

        // Random traffic: idle cycles, occasional sof and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) reset_dut();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
